// File: rtl/cic_interpolator_if.sv
// Stream bundle for the CIC interpolator: low-rate input stream and
// upsampled output stream, both AXI-stream style valid/ready.
interface cic_interpolator_if #(
    parameter int WIDTH     = 16,
    parameter int REG_WIDTH = 27
);
    logic [WIDTH-1:0]     input_tdata;
    logic                 input_tvalid;
    logic                 input_tready;
    logic [REG_WIDTH-1:0] output_tdata;
    logic                 output_tvalid;
    logic                 output_tready;

    modport master (
        output input_tdata, input_tvalid, output_tready,
        input  input_tready, output_tdata, output_tvalid
    );

    modport slave (
        input  input_tdata, input_tvalid, output_tready,
        output input_tready, output_tdata, output_tvalid
    );
endinterface

// File: rtl/cic_interpolator.sv
// CIC interpolator: N combs at input rate, zero-stuffing by a runtime rate,
// then N integrators at output rate. Output is unnormalised, modulo 2^REG_WIDTH.
module cic_interpolator #(
    parameter int WIDTH     = 16,
    parameter int RMAX      = 2048,
    parameter int M         = 1,
    parameter int N         = 2,
    parameter int REG_WIDTH = WIDTH + $clog2((RMAX * M) ** N / RMAX)
) (
    input  logic                       clk,
    input  logic                       rst,
    cic_interpolator_if.slave          axis,
    input  logic [$clog2(RMAX+1)-1:0]  rate
);
    localparam int RATE_W = $clog2(RMAX + 1);
    localparam int CW     = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RATE_W:0] RMAX_C = (RATE_W + 1)'(RMAX);
    localparam logic [RATE_W:0] ONE_C  = (RATE_W + 1)'(1);

    logic [CW-1:0]                cycle_reg;
    logic [CW-1:0]                cycle_next;
    logic [RATE_W:0]              cycle_inc;
    logic                         burst_start;
    logic                         in_xfer;
    logic                         out_xfer;
    logic [REG_WIDTH-1:0]         din_ext;
    logic [N-1:0][REG_WIDTH-1:0]  comb_bus;
    logic [N-1:0][REG_WIDTH-1:0]  int_bus;

    assign burst_start        = (cycle_reg == '0);
    assign axis.input_tready  = axis.output_tready & burst_start;
    assign axis.output_tvalid = axis.input_tvalid | ~burst_start;
    assign in_xfer            = axis.input_tvalid & axis.input_tready;
    assign out_xfer           = axis.output_tvalid & axis.output_tready;
    assign din_ext            = {{(REG_WIDTH - WIDTH){axis.input_tdata[WIDTH-1]}}, axis.input_tdata};

    // Compare cycle+1 against both limits so rate 0/1 collapse to pass-through
    // and any rate above RMAX saturates at RMAX.
    assign cycle_inc = {{(RATE_W + 1 - CW){1'b0}}, cycle_reg} + ONE_C;

    always_comb begin
        cycle_next = '0;
        if ((cycle_inc < RMAX_C) && (cycle_inc < {1'b0, rate}))
            cycle_next = cycle_inc[CW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cycle_reg <= '0;
        else if (out_xfer)
            cycle_reg <= cycle_next;
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_comb
            logic [REG_WIDTH-1:0]         comb_in;
            logic [REG_WIDTH-1:0]         comb_reg;
            logic [M-1:0][REG_WIDTH-1:0]  dly_reg;

            if (gi == 0) begin : g_first
                assign comb_in = din_ext;
            end else begin : g_chain
                assign comb_in = comb_bus[gi-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    comb_reg <= '0;
                    dly_reg  <= '0;
                end else if (in_xfer) begin
                    comb_reg   <= comb_in - dly_reg[M-1];
                    dly_reg[0] <= comb_in;
                    for (int j = 1; j < M; j++)
                        dly_reg[j] <= dly_reg[j-1];
                end
            end

            assign comb_bus[gi] = comb_reg;
        end

        for (genvar gi = 0; gi < N; gi++) begin : g_integ
            logic [REG_WIDTH-1:0] int_in;
            logic [REG_WIDTH-1:0] int_reg;

            // First integrator sees the comb output only on the first beat of
            // a burst; the remaining beats are the stuffed zeros.
            if (gi == 0) begin : g_first
                assign int_in = burst_start ? comb_bus[N-1] : '0;
            end else begin : g_chain
                assign int_in = int_bus[gi-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    int_reg <= '0;
                else if (out_xfer)
                    int_reg <= int_reg + int_in;
            end

            assign int_bus[gi] = int_reg;
        end
    endgenerate

    assign axis.output_tdata = int_bus[N-1];
endmodule

// File: tb/tb_cic_interpolator.sv
// Randomised bench for cic_interpolator against a closed-form CIC model:
// N-th order comb difference of the accepted samples, weighted by binomial ramps.
module tb_cic_interpolator;
    localparam int WIDTH  = 16;
    localparam int RMAX   = 2048;
    localparam int M      = 1;
    localparam int N      = 2;
    localparam int RW     = 27;
    localparam int RATE_W = $clog2(RMAX + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [RATE_W-1:0] rate = '0;

    cic_interpolator_if #(.WIDTH(WIDTH), .REG_WIDTH(RW)) axis ();

    cic_interpolator #(
        .WIDTH(WIDTH), .RMAX(RMAX), .M(M), .N(N), .REG_WIDTH(RW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .axis (axis.slave),
        .rate (rate)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: accepted samples, and the stuffed comb outputs placed on
    // the output-transfer timeline (transfer index, value).
    longint xs[$];
    longint sig_t[$];
    longint sig_a[$];
    longint t_cnt;
    int     pos;

    function automatic int reff();
        int r;
        r = int'(rate);
        if (r < 1) r = 1;
        if (r > RMAX) r = RMAX;
        return r;
    endfunction

    function automatic longint xv(int j);
        if (j < 0) return 0;
        return xs[j];
    endfunction

    function automatic longint diff(int k, int j);
        if (k == 0) return xv(j);
        return diff(k - 1, j) - diff(k - 1, j - M);
    endfunction

    function automatic longint binom(longint d, int k);
        longint r;
        if (d < k) return 0;
        r = 1;
        for (int i = 0; i < k; i++) r = r * (d - i) / (i + 1);
        return r;
    endfunction

    // Output after transfer t: each stuffed sample contributes a(t-s choose N-1).
    function automatic longint y_after(longint t);
        longint s;
        s = 0;
        if (t < 0) return 0;
        for (int i = 0; i < sig_t.size(); i++)
            if (sig_t[i] <= t) s += sig_a[i] * binom(t - sig_t[i], N - 1);
        return s;
    endfunction

    function automatic longint trunc(longint v);
        logic signed [RW-1:0] tv;
        tv = v[RW-1:0];
        return longint'(tv);
    endfunction

    function automatic void model_reset();
        xs.delete();
        sig_t.delete();
        sig_a.delete();
        t_cnt = 0;
        pos   = 0;
    endfunction

    function automatic void model_xfer(longint din);
        longint a;
        int     j;
        if (pos == 0) begin
            j = xs.size();
            a = diff(N, j - N);
            if (a != 0) begin
                sig_t.push_back(t_cnt);
                sig_a.push_back(a);
            end
            xs.push_back(din);
        end
        t_cnt++;
        pos = (pos + 1 < reff()) ? pos + 1 : 0;
    endfunction

    task automatic cycle(input bit iv, input longint din, input bit ordy, input string tag,
                         output longint obs, output bit obs_v, output longint done);
        bit exp_ir;
        bit exp_ov;
        @(negedge clk);
        axis.input_tvalid  = iv;
        axis.input_tdata   = din[WIDTH-1:0];
        axis.output_tready = ordy;
        #1;
        exp_ir = ordy && (pos == 0);
        exp_ov = iv || (pos != 0);
        done   = t_cnt;
        obs    = longint'($signed(axis.output_tdata));
        obs_v  = axis.output_tvalid;
        check({tag, "_itready"}, axis.input_tready, exp_ir);
        check({tag, "_otvalid"}, axis.output_tvalid, exp_ov);
        check({tag, "_otdata"}, $signed(axis.output_tdata), trunc(y_after(t_cnt - 1)));
        if (exp_ov && ordy) model_xfer(din);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        axis.input_tvalid  = 1'b0;
        axis.input_tdata   = '0;
        axis.output_tready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    int imp_tbl[8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    int rate_tbl[6] = '{0, 2, 3, 5, 7, 4095};

    initial begin
        longint obs;
        longint done;
        longint din;
        bit     obs_v;
        int     gap;
        int     stall;

        model_reset();
        axis.input_tvalid  = 1'b0;
        axis.input_tdata   = '0;
        axis.output_tready = 1'b0;
        rate = 4;
        #2;
        check("rst_tdata", $signed(axis.output_tdata), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_itready_lo", axis.input_tready, 0);
        axis.output_tready = 1'b1;
        #1;
        check("rel_itready_hi", axis.input_tready, 1);
        check("rel_otvalid_lo", axis.output_tvalid, 0);
        axis.input_tvalid = 1'b1;
        #1;
        check("rel_otvalid_hi", axis.output_tvalid, 1);

        // Impulse, free-running
        do_reset();
        rate = 4;
        for (int c = 0; c < 40; c++) begin
            cycle(1'b1, (c == 0) ? 1 : 0, 1'b1, "imp", obs, obs_v, done);
            if (done >= 10 && done <= 17) check("imp_seq", obs, imp_tbl[done - 10]);
        end
        $display("[TB] impulse rate=4 transfers=%0d", t_cnt);

        // Impulse with random backpressure
        do_reset();
        rate = 4;
        for (int c = 0; c < 120; c++) begin
            din = (xs.size() == 0) ? 1 : 0;
            cycle(1'b1, din, 1'($urandom_range(0, 1)), "bp", obs, obs_v, done);
            if (done >= 10 && done <= 17) check("bp_seq", obs, imp_tbl[done - 10]);
        end
        $display("[TB] backpressure impulse transfers=%0d", t_cnt);

        // DC 1000 at rate 4, then asynchronous reset mid-burst
        do_reset();
        rate = 4;
        for (int c = 0; c < 60; c++) cycle(1'b1, 1000, 1'b1, "dc", obs, obs_v, done);
        check("dc_settle", obs, 4000);
        for (int c = 0; c < 8 && pos == 0; c++) cycle(1'b1, 1000, 1'b1, "dc", obs, obs_v, done);
        @(posedge clk);
        #3;
        axis.input_tvalid  = 1'b0;
        axis.output_tready = 1'b1;
        #1;
        check("pre_rst_tdata", $signed(axis.output_tdata), 4000);
        check("pre_rst_otvalid", axis.output_tvalid, 1);
        rst = 1'b1;
        #1;
        check("async_rst_tdata", $signed(axis.output_tdata), 0);
        check("async_rst_otvalid", axis.output_tvalid, 0);
        check("async_rst_itready", axis.input_tready, 1);
        $display("[TB] dc 1000 rate=4 and async reset done");

        // Negative full-scale DC at maximum rate
        do_reset();
        rate = RATE_W'(RMAX);
        for (int c = 0; c < 6400; c++) cycle(1'b1, -32768, 1'b1, "nfs", obs, obs_v, done);
        check("nfs_settle", obs, -32768 * 2048);
        $display("[TB] negative full-scale rate=%0d transfers=%0d", RMAX, t_cnt);

        // Starvation at a burst boundary
        do_reset();
        rate  = 4;
        gap   = 0;
        stall = 0;
        for (int c = 0; c < 70; c++) begin
            bit iv;
            iv = 1'b1;
            if (c >= 20 && stall < 10 && pos == 0) begin
                iv = 1'b0;
                stall++;
            end
            din = longint'($urandom_range(0, 65535)) - 32768;
            cycle(iv, din, 1'b1, "starve", obs, obs_v, done);
            if (!obs_v) gap++;
        end
        check("starve_gap", gap, 10);
        $display("[TB] starvation gap=%0d", gap);

        // Pass-through ramp
        do_reset();
        rate = 1;
        for (int c = 0; c < 40; c++) begin
            cycle(1'b1, xs.size(), 1'($urandom_range(0, 3) != 0), "pass", obs, obs_v, done);
            check("pass_delay", obs, (done >= 4) ? done - 4 : 0);
        end
        $display("[TB] pass-through transfers=%0d", t_cnt);

        // Random data, valid and ready over several rates
        for (int r = 0; r < 6; r++) begin
            do_reset();
            rate = RATE_W'(rate_tbl[r]);
            for (int c = 0; c < 150; c++) begin
                din = longint'($urandom_range(0, 65535)) - 32768;
                cycle(1'($urandom_range(0, 3) != 0), din, 1'($urandom_range(0, 3) != 0),
                      "rnd", obs, obs_v, done);
            end
            $display("[TB] random rate=%0d transfers=%0d", rate_tbl[r], t_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
